ipml_prefetch_stage_v2: RTL and testbench
=========================================

IPML_PREFETCH_STAGE_V2 -- requirements
Module: ipml_prefetch_stage_v2

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data width; legal range 1..1152.
REQ-002 SHALL have parameter RAM_LAT, default 1, RAM read latency in rd_clk cycles; legal values 1 or 2.
REQ-003 SHALL have parameter SKID_DEPTH, default 2, output buffer entries; legal range RAM_LAT+1..8.
REQ-004 SHALL have parameter CNT_W, default 4, count width, constrained to at least clog2(SKID_DEPTH+1).
REQ-005 SHALL have port rd_clk, input, 1: read clock; all logic on the rising edge.
REQ-006 SHALL have port rd_rst, input, 1: reset, asynchronous, active-high.
REQ-007 SHALL have port ram_empty, input, 1: source FIFO empty flag.
REQ-008 SHALL have port ram_rd_en, output, 1: RAM read request, one word per asserted cycle.
REQ-009 SHALL have port ram_rd_data, input, DATA_W: RAM data, valid RAM_LAT cycles after the ram_rd_en cycle.
REQ-010 SHALL have port flush, input, 1: synchronous discard of all buffered and in-flight words.
REQ-011 SHALL have port rd_en, input, 1: consumer ready.
REQ-012 SHALL have port rd_data, output, DATA_W: head word.
REQ-013 SHALL have port rd_vld, output, 1: head word valid.
REQ-014 SHALL have port rd_count, output, CNT_W: words held in the skid buffer.

Function
REQ-015 SHALL define pop = rd_vld & rd_en; a word is consumed only on pop.
REQ-016 SHALL keep occ (buffered words) and infl (issued, not yet returned, 0..RAM_LAT).
REQ-017 SHALL drive ram_rd_en = ~ram_empty & ~flush & ((occ + infl - pop) < SKID_DEPTH), combinationally.
REQ-018 SHALL track returns with a RAM_LAT-deep valid shift register fed by ram_rd_en; its last stage is ret_vld.
REQ-019 SHALL write ram_rd_data into the skid buffer at wr_ptr on each edge where ret_vld=1; it shall not overflow under REQ-017.
REQ-020 SHALL implement the skid buffer as a SKID_DEPTH-entry circular register array; wr_ptr and rd_ptr wrap from SKID_DEPTH-1 to 0, including non-power-of-2 depths.
REQ-021 SHALL drive rd_data = entry[rd_ptr] and rd_vld = (occ != 0), both from registers.
REQ-022 SHALL hold rd_data and rd_vld stable while rd_vld=1 and rd_en=0.
REQ-023 SHALL, on simultaneous ret_vld and pop, keep occ unchanged and advance both pointers.
REQ-024 SHALL, when a pop occurs with occ=1 and ret_vld=1, present the returned word at the next cycle with rd_vld=1 (no bubble).
REQ-025 SHALL give first-word latency of RAM_LAT+1 cycles from the first ram_rd_en cycle to rd_vld=1.
REQ-026 SHALL sustain one pop per cycle indefinitely when ram_empty=0 and rd_en=1.
REQ-027 SHALL, on flush=1 at an edge, set occ=0, wr_ptr=rd_ptr=0 and clear the return shift register; words returning later from reads issued before the flush are discarded.
REQ-028 SHALL ignore rd_en during a flush cycle; a pop coincident with flush has no further effect.
REQ-029 SHALL drive rd_count = occ, zero-extended to CNT_W.
REQ-030 SHALL treat rd_en with rd_vld=0 as a no-op.

Reset
REQ-031 SHALL, while rd_rst=1, force occ=0, infl=0, pointers=0, return shift register=0, rd_vld=0, rd_count=0, rd_data=0 and all buffer entries=0.
REQ-032 SHALL gate ram_rd_en to 0 while rd_rst=1.
REQ-033 SHALL discard in-flight words when rd_rst asserts mid-operation; after release, the first word shall be fetched per REQ-017.

Verification
REQ-034 SHALL cover prefill: RAM_LAT=1, SKID_DEPTH=2, ram_empty=0, rd_en=0 -> exactly 2 ram_rd_en pulses, rd_vld at cycle 2, rd_count=2, ram_rd_en then stays 0.
REQ-035 SHALL cover streaming: RAM_LAT=2, SKID_DEPTH=3, words 0..99, rd_en=1 -> 100 pops in order with no gap after the first word, rd_count <= 3 throughout.
REQ-036 SHALL cover backpressure: rd_en random at 30% duty, SKID_DEPTH=5 -> no loss or duplication, rd_data stable while stalled, correct pointer wrap past index 4.
REQ-037 SHALL cover flush: flush with rd_count=2 and 1 word in flight -> next cycle rd_vld=0, rd_count=0; the in-flight word is never presented.
REQ-038 SHALL cover source drain: ram_empty=1 after word 7 -> rd_vld=1 until word 7 pops, then rd_vld=0 and ram_rd_en=0.
REQ-039 SHALL cover mid-operation reset: rd_rst pulsed with rd_count=2 -> rd_vld=0 and rd_data=0 immediately (async); normal fetch resumes after release.

Source files
------------

// File: rtl/ipml_prefetch_stage_v2.sv
// Prefetch stage between a RAM-backed source FIFO and a streaming consumer.
//
// Reads are issued speculatively whenever the source is not empty and the skid buffer
// plus the reads still in flight leave room for one more word. Returned words land in a
// small circular register array; the head entry is presented on rd_data/rd_vld straight
// from registers.
//
// Parameters:
//   DATA_W     data width (1..1152)
//   RAM_LAT    RAM read latency in rd_clk cycles (1 or 2)
//   SKID_DEPTH skid buffer entries (RAM_LAT+1..8)
//   CNT_W      rd_count width, at least clog2(SKID_DEPTH+1)
//
// Ports:
//   rd_clk       read clock, rising edge
//   rd_rst       asynchronous active-high reset
//   ram_empty    source FIFO empty flag
//   ram_rd_en    RAM read request, one word per asserted cycle
//   ram_rd_data  RAM data, valid RAM_LAT cycles after the request
//   flush        synchronous discard of buffered and in-flight words
//   rd_en        consumer ready
//   rd_data      head word
//   rd_vld       head word valid
//   rd_count     words held in the skid buffer
module ipml_prefetch_stage_v2 #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned RAM_LAT    = 1,
  parameter int unsigned SKID_DEPTH = 2,
  parameter int unsigned CNT_W      = 4
) (
  input  logic              rd_clk,
  input  logic              rd_rst,
  input  logic              ram_empty,
  output logic              ram_rd_en,
  input  logic [DATA_W-1:0] ram_rd_data,
  input  logic              flush,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_vld,
  output logic [CNT_W-1:0]  rd_count
);

  localparam int unsigned PTR_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam int unsigned OCC_W = $clog2(SKID_DEPTH + 1);
  localparam int unsigned INF_W = $clog2(RAM_LAT + 1);
  // One extra bit so occ + infl never wraps (infl <= RAM_LAT < SKID_DEPTH).
  localparam int unsigned SUM_W = OCC_W + 1;

  logic [OCC_W-1:0]   occ_q, occ_d;
  logic [INF_W-1:0]   infl_q, infl_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [RAM_LAT-1:0] ret_sr_q, ret_sr_d;
  logic [DATA_W-1:0]  mem_q [SKID_DEPTH];

  logic             ret_vld;
  logic             pop;
  logic [SUM_W-1:0] need;

  // Circular increment that also wraps for non-power-of-2 depths.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(SKID_DEPTH - 1)) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  assign ret_vld = ret_sr_q[RAM_LAT-1];
  assign rd_vld  = (occ_q != '0);
  assign pop     = rd_vld & rd_en;
  assign rd_data = mem_q[rd_ptr_q];
  assign rd_count = CNT_W'(occ_q);

  // Words the buffer must be able to hold if nothing else is requested; the word popped
  // this cycle frees its slot in time for a new request.
  assign need = SUM_W'(occ_q) + SUM_W'(infl_q) - SUM_W'(pop);

  assign ram_rd_en = ~rd_rst & ~ram_empty & ~flush & (need < SUM_W'(SKID_DEPTH));

  always_comb begin
    occ_d    = occ_q;
    infl_d   = infl_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ret_sr_d = ret_sr_q;
    if (flush) begin
      // Everything buffered or returning is dropped; pop is ignored this cycle.
      occ_d    = '0;
      infl_d   = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      ret_sr_d = '0;
    end else begin
      ret_sr_d[0] = ram_rd_en;
      for (int unsigned i = 1; i < RAM_LAT; i++) begin
        ret_sr_d[i] = ret_sr_q[i-1];
      end
      infl_d = infl_q + INF_W'(ram_rd_en) - INF_W'(ret_vld);
      if (ret_vld) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      if (ret_vld && !pop) begin
        occ_d = occ_q + OCC_W'(1);
      end else if (!ret_vld && pop) begin
        occ_d = occ_q - OCC_W'(1);
      end
    end
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      occ_q    <= '0;
      infl_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ret_sr_q <= '0;
    end else begin
      occ_q    <= occ_d;
      infl_q   <= infl_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ret_sr_q <= ret_sr_d;
    end
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      for (int i = 0; i < int'(SKID_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (ret_vld && !flush) begin
      mem_q[wr_ptr_q] <= ram_rd_data;
    end
  end

endmodule

// File: tb/tb_ipml_prefetch_stage_v2.sv
`timescale 1ns/1ps
module tb_ipml_prefetch_stage_v2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Instance 0: RAM_LAT=1 SKID=2; instance 1: RAM_LAT=2 SKID=3; instance 2: RAM_LAT=2 SKID=5.
  for (genvar k = 0; k < 3; k++) begin : g_dut
    localparam int unsigned LAT = (k == 0) ? 1 : 2;
    localparam int unsigned DEP = (k == 0) ? 2 : ((k == 1) ? 3 : 5);

    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        rd_en = 1'b0;
    logic        ram_empty, ram_rd_en, rd_vld;
    logic [31:0] ram_rd_data, rd_data;
    logic [31:0] d1 = '0;
    logic [31:0] d2 = '0;
    logic [31:0] prev_data = '0;
    logic [3:0]  rd_count;
    logic        prev_stall = 1'b0;
    int unsigned src_cnt = 0;
    int unsigned lim = 0;
    int unsigned n_pop = 0;
    int unsigned exp_q[$];

    // Source holds words src_cnt, src_cnt+1, ... up to lim-1.
    assign ram_empty   = (src_cnt >= lim);
    assign ram_rd_data = (LAT == 1) ? d1 : d2;

    ipml_prefetch_stage_v2 #(
      .DATA_W    (32),
      .RAM_LAT   (LAT),
      .SKID_DEPTH(DEP),
      .CNT_W     (4)
    ) u_dut (
      .rd_clk     (clk),
      .rd_rst     (rst),
      .ram_empty  (ram_empty),
      .ram_rd_en  (ram_rd_en),
      .ram_rd_data(ram_rd_data),
      .flush      (flush),
      .rd_en      (rd_en),
      .rd_data    (rd_data),
      .rd_vld     (rd_vld),
      .rd_count   (rd_count)
    );

    // RAM model plus scoreboard push on every issued read.
    always @(posedge clk) begin
      d1 <= ram_rd_en ? src_cnt : 32'hdead_beef;
      d2 <= d1;
      if (rst || flush) begin
        exp_q.delete();
      end else if (ram_rd_en) begin
        exp_q.push_back(src_cnt);
        src_cnt <= src_cnt + 1;
      end
    end

    // Pop comparison and stall stability, sampled mid-cycle.
    always @(negedge clk) begin
      if (rst) begin
        prev_stall <= 1'b0;
      end else begin
        if (prev_stall) begin
          check_eq($sformatf("stall_vld%0d", k), rd_vld, 1);
          check_eq($sformatf("stall_data%0d", k), rd_data, prev_data);
        end
        if (rd_vld && rd_en && !flush) begin
          check_eq($sformatf("pop_expected%0d", k), exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            check_eq($sformatf("pop_data%0d", k), rd_data, exp_q.pop_front());
          end
          n_pop <= n_pop + 1;
        end
        prev_stall <= rd_vld && !rd_en && !flush;
        prev_data  <= rd_data;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int  pulses;
    int  first_vld;
    int  cyc;
    int  base;
    bit  done;

    // Reset state
    #1;
    g_dut[0].rst = 1'b1;
    g_dut[1].rst = 1'b1;
    g_dut[2].rst = 1'b1;
    g_dut[0].lim = 100;
    #1;
    check_eq("rst_vld", g_dut[0].rd_vld, 0);
    check_eq("rst_count", g_dut[0].rd_count, 0);
    check_eq("rst_data", g_dut[0].rd_data, 0);
    check_eq("rst_ram_rd_en", g_dut[0].ram_rd_en, 0);
    check_eq("rst_vld2", g_dut[2].rd_vld, 0);
    check_eq("rst_count2", g_dut[2].rd_count, 0);
    tick(2);
    g_dut[1].rst = 1'b0;
    g_dut[2].rst = 1'b0;

    // Prefill: RAM_LAT=1, SKID=2, consumer idle
    g_dut[0].rst = 1'b0;
    pulses = 0;
    first_vld = -1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (g_dut[0].ram_rd_en) pulses++;
      if (g_dut[0].rd_vld && first_vld < 0) first_vld = i;
      tick();
    end
    check_eq("prefill_pulses", pulses, 2);
    check_eq("prefill_first_vld", first_vld, 2);
    check_eq("prefill_count", g_dut[0].rd_count, 2);
    check_eq("prefill_ram_rd_en", g_dut[0].ram_rd_en, 0);
    check_eq("prefill_head", g_dut[0].rd_data, 0);

    // Source drain after word 7
    g_dut[0].lim = 8;
    g_dut[0].rd_en = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      check_eq("drain_vld", g_dut[0].rd_vld, 1);
      if (g_dut[0].rd_vld && g_dut[0].rd_data == 7) done = 1'b1;
      tick();
    end
    check_eq("drain_done", done, 1);
    check_eq("drain_vld_off", g_dut[0].rd_vld, 0);
    check_eq("drain_ram_rd_en", g_dut[0].ram_rd_en, 0);
    check_eq("drain_count", g_dut[0].rd_count, 0);
    check_eq("drain_pops", g_dut[0].n_pop, 8);
    g_dut[0].rd_en = 1'b0;

    // Mid-operation reset with two words buffered
    g_dut[0].lim = g_dut[0].src_cnt + 2;
    cyc = 0;
    while (g_dut[0].rd_count != 2 && cyc < 20) begin
      tick();
      cyc++;
    end
    check_eq("mr_fill", g_dut[0].rd_count, 2);
    #2;
    g_dut[0].rst = 1'b1;
    #1;
    check_eq("mr_vld", g_dut[0].rd_vld, 0);
    check_eq("mr_data", g_dut[0].rd_data, 0);
    check_eq("mr_count", g_dut[0].rd_count, 0);
    check_eq("mr_ram_rd_en", g_dut[0].ram_rd_en, 0);
    tick();
    g_dut[0].rst = 1'b0;
    g_dut[0].lim = g_dut[0].src_cnt + 1;
    @(negedge clk);
    check_eq("mr_resume", g_dut[0].ram_rd_en, 1);
    cyc = 0;
    while (!g_dut[0].rd_vld && cyc < 10) begin
      tick();
      cyc++;
    end
    check_eq("mr_latency", cyc, 2);
    check_eq("mr_word", g_dut[0].rd_data, 10);
    g_dut[0].rd_en = 1'b1;
    tick();
    g_dut[0].rd_en = 1'b0;
    check_eq("mr_empty", g_dut[0].rd_vld, 0);

    // Streaming: RAM_LAT=2, SKID=3, words 0..99
    g_dut[1].lim = 100;
    g_dut[1].rd_en = 1'b1;
    cyc = 0;
    while (!g_dut[1].rd_vld && cyc < 10) begin
      tick();
      cyc++;
    end
    check_eq("stream_latency", cyc, 3);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check_eq("stream_gap", g_dut[1].rd_vld, 1);
      check_eq("stream_count_max", g_dut[1].rd_count <= 3, 1);
      tick();
    end
    check_eq("stream_pops", g_dut[1].n_pop, 100);
    check_eq("stream_vld_end", g_dut[1].rd_vld, 0);
    check_eq("stream_q_empty", g_dut[1].exp_q.size(), 0);
    g_dut[1].rd_en = 1'b0;

    // Flush with two buffered and one in flight: RAM_LAT=2, SKID=5
    g_dut[2].lim = 3;
    cyc = 0;
    while (g_dut[2].rd_count != 2 && cyc < 10) begin
      tick();
      cyc++;
    end
    check_eq("flush_pre_count", g_dut[2].rd_count, 2);
    g_dut[2].flush = 1'b1;
    g_dut[2].rd_en = 1'b1;
    tick();
    g_dut[2].flush = 1'b0;
    g_dut[2].rd_en = 1'b0;
    check_eq("flush_vld", g_dut[2].rd_vld, 0);
    check_eq("flush_count", g_dut[2].rd_count, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_eq("flush_ghost", g_dut[2].rd_vld, 0);
      tick();
    end

    // Backpressure: 30% consumer duty, 60 words through 5 entries
    base = g_dut[2].n_pop;
    g_dut[2].lim = g_dut[2].src_cnt + 60;
    done = 1'b0;
    for (int i = 0; i < 1500 && !done; i++) begin
      g_dut[2].rd_en = ($urandom_range(0, 99) < 30);
      tick();
      if (g_dut[2].src_cnt >= g_dut[2].lim && g_dut[2].exp_q.size() == 0
          && !g_dut[2].rd_vld) begin
        done = 1'b1;
      end
    end
    g_dut[2].rd_en = 1'b0;
    check_eq("bp_done", done, 1);
    check_eq("bp_pops", g_dut[2].n_pop - base, 60);
    check_eq("bp_count_end", g_dut[2].rd_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
